// File: rtl/mips_uart_rx_if.sv
// mips_uart_rx_if: signal bundle between the UART receiver and the CPU side.
//   uart_in    - serial receive line, idle high (into receiver)
//   rd_en      - one-clk CPU read strobe acknowledging rx_data (into receiver)
//   rx_data    - last correctly framed byte
//   rx_valid   - rx_data holds an unread byte
//   overrun    - a byte was overwritten before being read
//   frame_err  - last frame had a low stop bit
//   shift_read - live receive shift register (debug)
//   busy       - receiver FSM not idle
// Modports: slave = receiver, master = CPU / bench.
interface mips_uart_rx_if;
  logic       uart_in;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic [7:0] shift_read;
  logic       busy;

  modport slave (
    input  uart_in, rd_en,
    output rx_data, rx_valid, overrun, frame_err, shift_read, busy
  );

  modport master (
    output uart_in, rd_en,
    input  rx_data, rx_valid, overrun, frame_err, shift_read, busy
  );
endinterface

// File: rtl/mips_uart_rx.sv
// mips_uart_rx: 8N1 UART receiver with a CPU-readable holding register.
// Oversamples uart_in at CLKS_PER_BIT clocks per bit, deserialises LSB first
// and reports data-valid, overrun and framing-error flags.
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - mips_uart_rx_if.slave (uart_in, rd_en in; rx_data, rx_valid,
//          overrun, frame_err, shift_read, busy out)
module mips_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  mips_uart_rx_if.slave   bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;

  logic       sync_p0, rxs;
  logic [7:0] shift_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q, overrun_q, frame_err_q;

  logic busy_c, sample_bit, stop_good, stop_bad;
  logic rd_ack;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync_p0 <= bus.uart_in;
      rxs     <= sync_p0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Re-check the line half a bit in, so short low glitches are dropped.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = rxs ? S_IDLE : S_BRK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BRK: begin
        // Hold here until the line returns high so a stuck-low line is not
        // decoded as a stream of 0x00 bytes.
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_c     = (state_q != S_IDLE);
    sample_bit = (state_q == S_DATA) && (cnt_q == FULL_M1);
    stop_good  = (state_q == S_STOP) && (cnt_q == FULL_M1) &&  rxs;
    stop_bad   = (state_q == S_STOP) && (cnt_q == FULL_M1) && !rxs;
  end

  // A read only acknowledges something when there is an unread byte.
  assign rd_ack = bus.rd_en && rx_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
    end else if (sample_bit) begin
      shift_q <= {rxs, shift_q[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (stop_good) begin
        rx_data_q   <= shift_q;
        rx_valid_q  <= 1'b1;
        frame_err_q <= 1'b0;
        // A read landing on the same edge consumes the old byte, so no overrun.
        if (rx_valid_q && !bus.rd_en) overrun_q <= 1'b1;
        else if (rd_ack)              overrun_q <= 1'b0;
      end else begin
        if (rd_ack) begin
          rx_valid_q <= 1'b0;
          overrun_q  <= 1'b0;
        end
        if (stop_bad) frame_err_q <= 1'b1;
      end
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.shift_read = shift_q;
  assign bus.busy       = busy_c;

endmodule

// File: tb/tb_mips_uart_rx.sv
module tb_mips_uart_rx;
  localparam int CPB = 16;
  // Line driven just after edge 0 reaches rxs at edge 2, START at edge 3;
  // the stop-bit sample edge follows half a bit plus nine bits later.
  localparam int SAMPLE_I = 3 + CPB/2 + 9*CPB;

  logic clk = 1'b0;
  logic rst;
  mips_uart_rx_if bus();

  mips_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Frame-level reference state
  logic [7:0] m_data, m_shift;
  logic       m_valid, m_ovr, m_ferr;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_shift = 8'h00;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rx_data"},    bus.rx_data,    m_data);
    chk({tag, ".rx_valid"},   {7'd0, bus.rx_valid},  {7'd0, m_valid});
    chk({tag, ".overrun"},    {7'd0, bus.overrun},   {7'd0, m_ovr});
    chk({tag, ".frame_err"},  {7'd0, bus.frame_err}, {7'd0, m_ferr});
    chk({tag, ".shift_read"}, bus.shift_read, m_shift);
    chk({tag, ".busy"},       {7'd0, bus.busy}, 8'd0);
  endtask

  task automatic pulse_rd();
    bus.rd_en = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  // Send one frame. nstop_low>0 drives the stop bit low for that many bit
  // times; rd_stop asserts rd_en on the stop-sample cycle; abort_at >= 0
  // asserts reset at that clock of the frame.
  task automatic send(input logic [7:0] b, input int nstop_low,
                      input bit rd_stop, input int abort_at);
    int nbits;
    int bi;
    logic v;
    nbits = (nstop_low > 0) ? 9 + nstop_low : 10;
    for (int i = 0; i < nbits*CPB; i++) begin
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_mid.rx_data",    bus.rx_data, 8'h00);
        chk("rst_mid.shift_read", bus.shift_read, 8'h00);
        chk("rst_mid.flags", {4'd0, bus.rx_valid, bus.overrun, bus.frame_err, bus.busy}, 8'h00);
        bus.uart_in = 1'b1;
        bus.rd_en   = 1'b0;
        return;
      end
      if (i == SAMPLE_I - 1)
        chk("pre_stop.rx_valid", {7'd0, bus.rx_valid}, {7'd0, m_valid});
      if (i == SAMPLE_I && nstop_low == 0) begin
        if (m_valid && !rd_stop) m_ovr = 1'b1;
        else if (rd_stop)        m_ovr = 1'b0;
        m_valid = 1'b1; m_data = b; m_ferr = 1'b0; m_shift = b;
        chk("stop.shift_read", bus.shift_read, b);
        chk("stop.rx_data",    bus.rx_data, b);
        chk("stop.rx_valid",   {7'd0, bus.rx_valid}, 8'd1);
        chk("stop.overrun",    {7'd0, bus.overrun}, {7'd0, m_ovr});
      end
      bi = i / CPB;
      if (bi == 0)      v = 1'b0;
      else if (bi <= 8) v = b[bi-1];
      else              v = (nstop_low > 0) ? 1'b0 : 1'b1;
      bus.uart_in = v;
      bus.rd_en   = rd_stop && (i == SAMPLE_I - 1);
      @(posedge clk); #1;
    end
    bus.rd_en = 1'b0;
    if (nstop_low > 0) begin
      m_ferr = 1'b1; m_shift = b;
      chk("brk.busy",      {7'd0, bus.busy}, 8'd1);
      chk("brk.frame_err", {7'd0, bus.frame_err}, 8'd1);
      chk("brk.rx_valid",  {7'd0, bus.rx_valid}, {7'd0, m_valid});
      chk("brk.shift",     bus.shift_read, b);
      bus.uart_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("brk_exit.busy", {7'd0, bus.busy}, 8'd0);
    end
    bus.uart_in = 1'b1;
  endtask

  initial begin
    logic [7:0] rb;
    bit         bad, rds;
    rst = 1'b0;
    bus.uart_in = 1'b1;
    bus.rd_en   = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check_model("idle");

    send(8'h55, 0, 1'b0, -1);
    check_model("b55");
    pulse_rd();
    check_model("rd55");
    send(8'hA5, 0, 1'b0, -1);
    check_model("bA5");
    pulse_rd();

    // Glitch on the line
    bus.uart_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.uart_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_model("glitch");

    // Framing error, then recovery
    send(8'h3C, 3, 1'b0, -1);
    chk("ferr.flag", {7'd0, bus.frame_err}, 8'd1);
    send(8'h81, 0, 1'b0, -1);
    check_model("b81");
    pulse_rd();

    // Overrun, then clear
    send(8'h11, 0, 1'b0, -1);
    send(8'h22, 0, 1'b0, -1);
    check_model("ovr");
    pulse_rd();
    check_model("ovr_clr");

    // Read coinciding with the stop sample of the second byte
    send(8'h11, 0, 1'b0, -1);
    send(8'h22, 0, 1'b1, -1);
    check_model("rd_at_stop");
    pulse_rd();

    // Reset during data bit 4
    send(8'hFF, 0, 1'b0, 5*CPB + 8);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_model("after_rst");
    send(8'h0F, 0, 1'b0, -1);
    check_model("b0F");

    // Randomised frames against the reference
    for (int n = 0; n < 8; n++) begin
      rb  = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      rds = bad ? 1'b0 : 1'($urandom_range(0, 1));
      send(rb, bad ? 1 : 0, rds, -1);
      check_model("rand");
      if ($urandom_range(0, 1) == 1) begin
        pulse_rd();
        check_model("rand_rd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
